// File: rtl/riscv_alu_issue.sv
// Execute-stage issue register: decodes RV32I fields into ALU operands/control
// and presents them through a valid/ready stage backed by a 2-entry skid buffer.

package riscv_alu_issue_pkg;
    typedef enum logic [3:0] {
        ALU_CTRL_ADD  = 4'd0,
        ALU_CTRL_SUB  = 4'd1,
        ALU_CTRL_SLL  = 4'd2,
        ALU_CTRL_SLT  = 4'd3,
        ALU_CTRL_SLTU = 4'd4,
        ALU_CTRL_XOR  = 4'd5,
        ALU_CTRL_SRL  = 4'd6,
        ALU_CTRL_SRA  = 4'd7,
        ALU_CTRL_OR   = 4'd8,
        ALU_CTRL_AND  = 4'd9
    } alu_ctrl_e;
endpackage

module riscv_alu_issue
    import riscv_alu_issue_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic            i_funct7b5,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_alu_a,
    output logic [XLEN-1:0] o_alu_b,
    output logic [3:0]      o_alu_ctrl,
    output logic            o_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        alu_ctrl_e       ctrl;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RST = '{a: '0, b: '0, ctrl: ALU_CTRL_ADD, illegal: 1'b0};

    entry_t dec;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept, consume;

    always_comb begin
        dec = '{a: i_rs1_data, b: i_rs2_data, ctrl: ALU_CTRL_ADD, illegal: 1'b0};
        unique case (i_opcode)
            OPC_OP, OPC_OP_IMM: begin
                if (i_opcode == OPC_OP_IMM) begin
                    dec.b = i_imm;
                end
                unique case (i_funct3)
                    3'b000:  dec.ctrl = (i_opcode == OPC_OP && i_funct7b5) ? ALU_CTRL_SUB : ALU_CTRL_ADD;
                    3'b001:  dec.ctrl = ALU_CTRL_SLL;
                    3'b010:  dec.ctrl = ALU_CTRL_SLT;
                    3'b011:  dec.ctrl = ALU_CTRL_SLTU;
                    3'b100:  dec.ctrl = ALU_CTRL_XOR;
                    3'b101:  dec.ctrl = i_funct7b5 ? ALU_CTRL_SRA : ALU_CTRL_SRL;
                    3'b110:  dec.ctrl = ALU_CTRL_OR;
                    default: dec.ctrl = ALU_CTRL_AND;
                endcase
            end
            OPC_LUI: begin
                dec.a = '0;
                dec.b = i_imm;
            end
            OPC_AUIPC: begin
                dec.a = i_pc;
                dec.b = i_imm;
            end
            OPC_LOAD, OPC_STORE: begin
                dec.b = i_imm;
            end
            OPC_BRANCH: begin
                unique case (i_funct3)
                    3'b000, 3'b001: dec.ctrl = ALU_CTRL_SUB;
                    3'b100, 3'b101: dec.ctrl = ALU_CTRL_SLT;
                    3'b110, 3'b111: dec.ctrl = ALU_CTRL_SLTU;
                    default:        dec.illegal = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                dec.a = i_pc;
                dec.b = XLEN'(4);
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign o_ready = ~skid_valid_q;
    assign accept  = i_valid & o_ready;
    assign consume = main_valid_q & i_ready;

    // Skid is only ever filled while main is stalled, so FIFO order is main then skid.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (i_flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = dec;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            main_q       <= ENTRY_RST;
            skid_q       <= ENTRY_RST;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign o_valid    = main_valid_q;
    assign o_alu_a    = main_q.a;
    assign o_alu_b    = main_q.b;
    assign o_alu_ctrl = main_q.ctrl;
    assign o_illegal  = main_q.illegal;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Bench for riscv_alu_issue: decode table streamed under random back-pressure,
// plus directed skid, flush and asynchronous-reset sequences.

module tb_riscv_alu_issue;
    import riscv_alu_issue_pkg::*;

    localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LUI = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [31:0] RS1 = 32'hA5A5_0001, RS2 = 32'h0F0F_0002;
    localparam logic [31:0] IMM = 32'h0000_0123, PC = 32'h0000_2000;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1, rs2, imm, pc;
        logic [31:0] ea, eb;
        logic [3:0]  ectrl;
        logic        eill;
        logic        chk_ctrl;
    } vec_t;

    typedef struct {
        logic [31:0] a, b;
        logic [3:0]  ctrl;
        logic        ill;
        logic        chk_ctrl;
        int          tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [6:0]  i_opcode = '0;
    logic [2:0]  i_funct3 = '0;
    logic        i_funct7b5 = 1'b0;
    logic [31:0] i_rs1_data = '0, i_rs2_data = '0, i_imm = '0, i_pc = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_alu_a, o_alu_b;
    logic [3:0]  o_alu_ctrl;
    logic        o_illegal;

    int   n_vec = 0;
    int   n_mis = 0;
    exp_t q[$];
    exp_t cur_exp;
    logic rand_ready = 1'b0;
    logic ready_force = 1'b0;
    vec_t vec[26];
    vec_t e1, e2, e3;

    riscv_alu_issue #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7b5(i_funct7b5),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm), .i_pc(i_pc),
        .o_valid(o_valid), .i_ready(i_ready), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
        .o_alu_ctrl(o_alu_ctrl), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        i_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Scoreboard: push on accept, pop and compare on consume; flush/reset empty it.
    always @(negedge clk) begin
        if (i_rst || i_flush) begin
            q.delete();
        end else begin
            if (o_valid && i_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_output: got a=%0h b=%0h ctrl=%0d, required no entry",
                             o_alu_a, o_alu_b, o_alu_ctrl);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (o_alu_a !== e.a || o_alu_b !== e.b || o_illegal !== e.ill ||
                        (e.chk_ctrl && o_alu_ctrl !== e.ctrl)) begin
                        n_mis++;
                        $display("FAIL entry#%0d: got a=%0h b=%0h ctrl=%0d ill=%0b, required a=%0h b=%0h ctrl=%0d ill=%0b",
                                 e.tag, o_alu_a, o_alu_b, o_alu_ctrl, o_illegal, e.a, e.b, e.ctrl, e.ill);
                    end
                end
            end
            if (i_valid && o_ready) q.push_back(cur_exp);
        end
    end

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic [3:0] ectrl, input logic eill, input logic chk);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
        v.ea = ea; v.eb = eb; v.ectrl = ectrl; v.eill = eill; v.chk_ctrl = chk;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the entry has been accepted.
    task automatic send(input vec_t v, input int tag);
        bit ok;
        i_opcode = v.op; i_funct3 = v.f3; i_funct7b5 = v.f7;
        i_rs1_data = v.rs1; i_rs2_data = v.rs2; i_imm = v.imm; i_pc = v.pc;
        cur_exp = '{a: v.ea, b: v.eb, ctrl: v.ectrl, ill: v.eill, chk_ctrl: v.chk_ctrl, tag: tag};
        i_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_mis++;
            $display("FAIL send_timeout#%0d: got o_ready=0 for 200 cycles, required 1", tag);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 300 && q.size() != 0; k++) @(posedge clk);
        check(name, q.size(), 0);
    endtask

    initial begin
        vec[0]  = mk(R_OP, 3'b000, 1'b1, 32'd10, 32'd3, IMM, PC, 32'd10, 32'd3, ALU_CTRL_SUB, 1'b0, 1'b1);
        vec[1]  = mk(R_OP, 3'b000, 1'b0, RS1, RS2, IMM, PC, RS1, RS2, ALU_CTRL_ADD, 1'b0, 1'b1);
        vec[2]  = mk(R_OP, 3'b001, 1'b0, RS1, RS2, IMM, PC, RS1, RS2, ALU_CTRL_SLL, 1'b0, 1'b1);
        vec[3]  = mk(R_OP, 3'b010, 1'b0, RS1, RS2, IMM, PC, RS1, RS2, ALU_CTRL_SLT, 1'b0, 1'b1);
        vec[4]  = mk(R_OP, 3'b011, 1'b0, RS1, RS2, IMM, PC, RS1, RS2, ALU_CTRL_SLTU, 1'b0, 1'b1);
        vec[5]  = mk(R_OP, 3'b100, 1'b0, RS1, RS2, IMM, PC, RS1, RS2, ALU_CTRL_XOR, 1'b0, 1'b1);
        vec[6]  = mk(R_OP, 3'b101, 1'b0, RS1, RS2, IMM, PC, RS1, RS2, ALU_CTRL_SRL, 1'b0, 1'b1);
        vec[7]  = mk(R_OP, 3'b101, 1'b1, RS1, RS2, IMM, PC, RS1, RS2, ALU_CTRL_SRA, 1'b0, 1'b1);
        vec[8]  = mk(R_OP, 3'b110, 1'b0, RS1, RS2, IMM, PC, RS1, RS2, ALU_CTRL_OR, 1'b0, 1'b1);
        vec[9]  = mk(R_OP, 3'b111, 1'b0, RS1, RS2, IMM, PC, RS1, RS2, ALU_CTRL_AND, 1'b0, 1'b1);
        vec[10] = mk(I_OP, 3'b000, 1'b1, RS1, RS2, 32'hFFFF_FFFF, PC, RS1, 32'hFFFF_FFFF, ALU_CTRL_ADD, 1'b0, 1'b1);
        vec[11] = mk(I_OP, 3'b101, 1'b1, RS1, RS2, IMM, PC, RS1, IMM, ALU_CTRL_SRA, 1'b0, 1'b1);
        vec[12] = mk(I_OP, 3'b101, 1'b0, RS1, RS2, IMM, PC, RS1, IMM, ALU_CTRL_SRL, 1'b0, 1'b1);
        vec[13] = mk(I_OP, 3'b011, 1'b1, RS1, RS2, IMM, PC, RS1, IMM, ALU_CTRL_SLTU, 1'b0, 1'b1);
        vec[14] = mk(LUI, 3'b000, 1'b0, RS1, RS2, 32'h1234_5000, PC, 32'h0, 32'h1234_5000, ALU_CTRL_ADD, 1'b0, 1'b1);
        vec[15] = mk(AUIPC, 3'b000, 1'b0, RS1, RS2, 32'h2000, 32'h1000, 32'h1000, 32'h2000, ALU_CTRL_ADD, 1'b0, 1'b1);
        vec[16] = mk(LD, 3'b010, 1'b0, RS1, RS2, IMM, PC, RS1, IMM, ALU_CTRL_ADD, 1'b0, 1'b1);
        vec[17] = mk(ST, 3'b010, 1'b1, RS1, RS2, IMM, PC, RS1, IMM, ALU_CTRL_ADD, 1'b0, 1'b1);
        vec[18] = mk(BR, 3'b001, 1'b0, RS1, RS2, IMM, PC, RS1, RS2, ALU_CTRL_SUB, 1'b0, 1'b1);
        vec[19] = mk(BR, 3'b101, 1'b0, RS1, RS2, IMM, PC, RS1, RS2, ALU_CTRL_SLT, 1'b0, 1'b1);
        vec[20] = mk(BR, 3'b110, 1'b0, RS1, RS2, IMM, PC, RS1, RS2, ALU_CTRL_SLTU, 1'b0, 1'b1);
        vec[21] = mk(BR, 3'b010, 1'b0, RS1, RS2, IMM, PC, RS1, RS2, ALU_CTRL_ADD, 1'b1, 1'b0);
        vec[22] = mk(JAL, 3'b000, 1'b0, RS1, RS2, IMM, 32'h40, 32'h40, 32'd4, ALU_CTRL_ADD, 1'b0, 1'b1);
        vec[23] = mk(JALR, 3'b000, 1'b0, RS1, RS2, IMM, 32'h88, 32'h88, 32'd4, ALU_CTRL_ADD, 1'b0, 1'b1);
        vec[24] = mk(7'b0000000, 3'b000, 1'b0, RS1, RS2, IMM, PC, RS1, RS2, ALU_CTRL_ADD, 1'b1, 1'b1);
        vec[25] = mk(7'b1111111, 3'b111, 1'b1, RS1, RS2, IMM, PC, RS1, RS2, ALU_CTRL_ADD, 1'b1, 1'b1);
        e1 = mk(R_OP, 3'b100, 1'b0, 32'h111, 32'h1, IMM, PC, 32'h111, 32'h1, ALU_CTRL_XOR, 1'b0, 1'b1);
        e2 = mk(LUI, 3'b000, 1'b0, RS1, RS2, 32'h222000, PC, 32'h0, 32'h222000, ALU_CTRL_ADD, 1'b0, 1'b1);
        e3 = mk(JAL, 3'b000, 1'b0, RS1, RS2, IMM, 32'h333, 32'h333, 32'd4, ALU_CTRL_ADD, 1'b0, 1'b1);

        // Reset and idle state
        repeat (3) @(negedge clk);
        #1 i_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 1);
        check("rst_a", o_alu_a, 0);
        check("rst_b", o_alu_b, 0);
        check("rst_ctrl", o_alu_ctrl, ALU_CTRL_ADD);
        check("rst_illegal", o_illegal, 0);

        // Decode table under random back-pressure
        rand_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 26; i++) send(vec[i], i);
        drain("table_drain");
        rand_ready = 1'b0;
        ready_force = 1'b0;

        // Back-pressure: E1 in main, E2 in skid, E3 held off
        @(posedge clk); #1;
        send(e1, 100);
        send(e2, 101);
        i_opcode = e3.op; i_funct3 = e3.f3; i_funct7b5 = e3.f7;
        i_rs1_data = e3.rs1; i_rs2_data = e3.rs2; i_imm = e3.imm; i_pc = e3.pc;
        cur_exp = '{a: e3.ea, b: e3.eb, ctrl: e3.ectrl, ill: e3.eill, chk_ctrl: 1'b1, tag: 102};
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_low", o_ready, 0);
            check("bp_valid", o_valid, 1);
            check("bp_hold_a", o_alu_a, e1.ea);
        end
        ready_force = 1'b1;
        @(negedge clk);
        check("bp_e1_out", o_valid, 1);
        @(negedge clk);
        check("bp_e2_out", o_valid, 1);
        check("bp_ready_back", o_ready, 1);
        @(posedge clk); #1 i_valid = 1'b0;
        @(negedge clk);
        check("bp_e3_out", o_valid, 1);
        check("bp_e3_a", o_alu_a, e3.ea);
        @(negedge clk);
        check("bp_empty", o_valid, 0);
        drain("bp_drain");

        // Flush with main and skid full while a third entry is offered
        ready_force = 1'b0;
        @(posedge clk); #1;
        send(e1, 200);
        send(e2, 201);
        i_opcode = e3.op; i_pc = e3.pc;
        cur_exp.tag = 202;
        i_valid = 1'b1;
        i_flush = 1'b1;
        @(negedge clk);
        check("fl_full", o_ready, 0);
        @(posedge clk); #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        check("fl_valid", o_valid, 0);
        check("fl_ready", o_ready, 1);
        ready_force = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fl_no_emit", o_valid, 0);
        end

        // Asynchronous reset between edges with an entry held
        ready_force = 1'b0;
        @(posedge clk); #1;
        send(e1, 300);
        @(negedge clk);
        check("ar_valid_before", o_valid, 1);
        #2 i_rst = 1'b1;
        #1;
        check("ar_valid", o_valid, 0);
        check("ar_ready", o_ready, 1);
        check("ar_a", o_alu_a, 0);
        check("ar_ctrl", o_alu_ctrl, ALU_CTRL_ADD);
        @(negedge clk);
        #1 i_rst = 1'b0;
        ready_force = 1'b1;
        @(posedge clk); #1;
        send(vec[0], 301);
        drain("ar_recover_drain");
        check("ar_recover_count", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
